// File: rtl/fetch_stage_if.sv
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response channel and the IF/ID
//                register bundle driven by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;

    // Registered IF/ID payload consumed by the decode stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_reg_t;

    // Request channel (valid/ready handshake).
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;

    // Response channel (in order, no back-pressure).
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    // IF/ID pipeline register.
    if_id_reg_t  if_id_reg;

    // Fetch-stage side.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output if_id_reg,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory / decode side.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  if_id_reg,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32IM instruction fetch stage. Owns the PC, keeps up to two
//                in-order requests in flight, buffers up to two returned
//                instructions and drives the IF/ID register. Honours decode
//                stall/flush and execute-stage redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        stall_d_i,
    input  wire logic        flush_d_i,
    input  wire logic        redirect_valid_i,
    input  wire logic [31:0] redirect_pc_i,
    fetch_stage_if.master    fif
);

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  c_DEPTH     = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [1:0]  r_out_cnt;
    logic [1:0]  r_discard_cnt;

    logic [31:0] r_tag [2];
    logic        r_tag_wr;
    logic        r_tag_rd;

    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic        r_buf_wr;
    logic        r_buf_rd;
    logic [1:0]  r_buf_cnt;

    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [2:0]  w_credit_used;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_rsp;
    logic [31:0] w_rsp_pc;
    logic        w_drop;
    logic        w_deliver;
    logic        w_if_id_load;
    logic        w_buf_empty;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [1:0]  w_out_cnt_nxt;
    logic [1:0]  w_discard_nxt;
    logic [1:0]  w_buf_cnt_nxt;
    logic [31:0] w_redirect_pc;
    logic [1:0]  w_unused_rpc;

    // Low bits of the redirect target are defined as don't-care.
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_rpc  = redirect_pc_i[1:0];

    // Request issue: every in-flight request owns a buffer slot, so the
    // buffer can never overflow however long decode stalls.
    always_comb begin
        w_credit_used = {1'b0, r_out_cnt} + {1'b0, r_buf_cnt};
        w_req_valid   = rst_ni & ~redirect_valid_i & (w_credit_used < 3'd2);
        w_accept      = w_req_valid & fif.imem_req_ready;
    end

    // Response routing: drop stale responses, else bypass or buffer.
    always_comb begin
        w_rsp        = fif.imem_rsp_valid & (r_out_cnt != 2'd0);
        w_rsp_pc     = r_tag[r_tag_rd];
        w_drop       = w_rsp & (redirect_valid_i | (r_discard_cnt != 2'd0));
        w_deliver    = w_rsp & ~w_drop;
        w_if_id_load = ~flush_d_i & ~stall_d_i;
        w_buf_empty  = (r_buf_cnt == 2'd0);
        w_pop        = w_if_id_load & ~w_buf_empty;
        w_bypass     = w_if_id_load & w_buf_empty & w_deliver;
        w_push       = w_deliver & ~w_bypass;
    end

    // Net counter updates when accept, response and pop coincide.
    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        if (w_accept && !w_rsp) begin
            w_out_cnt_nxt = r_out_cnt + 2'd1;
        end else if (!w_accept && w_rsp) begin
            w_out_cnt_nxt = r_out_cnt - 2'd1;
        end

        // A redirect marks everything still in flight (after this cycle's
        // response) as stale; redirects never coincide with an accept.
        w_discard_nxt = r_discard_cnt;
        if (redirect_valid_i) begin
            w_discard_nxt = w_out_cnt_nxt;
        end else if (w_rsp && (r_discard_cnt != 2'd0)) begin
            w_discard_nxt = r_discard_cnt - 2'd1;
        end

        w_buf_cnt_nxt = r_buf_cnt;
        if (redirect_valid_i) begin
            w_buf_cnt_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_buf_cnt_nxt = r_buf_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_buf_cnt_nxt = r_buf_cnt - 2'd1;
        end
    end

    // PC and request/discard counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc          <= RESET_VECTOR;
            r_out_cnt     <= 2'd0;
            r_discard_cnt <= 2'd0;
        end else begin
            if (redirect_valid_i) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            r_out_cnt     <= w_out_cnt_nxt;
            r_discard_cnt <= w_discard_nxt;
        end
    end

    // PC-tag FIFO; never cleared by redirect because stale responses still
    // have to pop their tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                r_tag[i] <= 32'd0;
            end
            r_tag_wr <= 1'b0;
            r_tag_rd <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag[r_tag_wr] <= r_pc;
                r_tag_wr        <= ~r_tag_wr;
            end
            if (w_rsp) begin
                r_tag_rd <= ~r_tag_rd;
            end
        end
    end

    // Instruction buffer holding {pc, instr} pairs awaiting decode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]    <= 32'd0;
                r_buf_instr[i] <= c_NOP_INSTR;
            end
            r_buf_wr  <= 1'b0;
            r_buf_rd  <= 1'b0;
            r_buf_cnt <= 2'd0;
        end else begin
            if (redirect_valid_i) begin
                r_buf_wr <= 1'b0;
                r_buf_rd <= 1'b0;
            end else begin
                if (w_push) begin
                    r_buf_pc[r_buf_wr]    <= w_rsp_pc;
                    r_buf_instr[r_buf_wr] <= fif.imem_rsp_data;
                    r_buf_wr              <= ~r_buf_wr;
                end
                if (w_pop) begin
                    r_buf_rd <= ~r_buf_rd;
                end
            end
            r_buf_cnt <= w_buf_cnt_nxt;
        end
    end

    // IF/ID register: flush beats stall, buffered entries beat the bypass.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= c_NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (flush_d_i) begin
            r_if_id_valid <= 1'b0;
        end else if (!stall_d_i) begin
            if (w_pop) begin
                r_if_id_pc    <= r_buf_pc[r_buf_rd];
                r_if_id_instr <= r_buf_instr[r_buf_rd];
                r_if_id_valid <= 1'b1;
            end else if (w_bypass) begin
                r_if_id_pc    <= w_rsp_pc;
                r_if_id_instr <= fif.imem_rsp_data;
                r_if_id_valid <= 1'b1;
            end else begin
                r_if_id_valid <= 1'b0;
            end
        end
    end

    // Structural invariants of the credit scheme.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_push && !w_pop && (r_buf_cnt == c_DEPTH)));
            assert (!(fif.imem_rsp_valid && (r_out_cnt == 2'd0)));
            assert ((r_out_cnt <= c_DEPTH) && (r_buf_cnt <= c_DEPTH));
            assert (r_discard_cnt <= r_out_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fif.imem_req_valid = w_req_valid;
    assign fif.imem_req_addr  = r_pc;
    assign fif.if_id_reg      = {r_if_id_pc, r_if_id_instr, r_if_id_valid};

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A memory model answers
//                requests in order with random latency; a queue-based model
//                of the fetch rules predicts request timing and IF/ID contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_RV       = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam int          c_HALF     = 5;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] redir_pc;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_VECTOR (c_RV)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .stall_d_i        (stall),
        .flush_d_i        (flush),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .fif              (fif)
    );

    initial clk = 1'b0;
    always #(c_HALF) clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       memq [$];   // requests accepted by memory, oldest first
    logic [31:0] mbuf [$];   // delivered instructions waiting for decode
    int          cyc;
    int          last_due;
    int          epoch;
    int          lat_min;
    int          lat_max;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] exp_req_pc;

    int errors;
    int checks;
    int p_stall, p_flush, p_redir, p_ready;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        mbuf.delete();
        last_due   = cyc;
        m_valid    = 1'b0;
        m_pc       = 32'd0;
        m_instr    = c_NOP;
        exp_req_pc = c_RV;
    endtask

    // One clock cycle: present memory response, check request side, clock,
    // advance the model, check IF/ID.
    task automatic tick();
        logic        rsp;
        logic        acc;
        logic [31:0] acc_addr;
        logic        live;
        logic        took;
        logic        exp_rv;
        mreq_t       head;
        mreq_t       nr;
        int          due;

        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        fif.imem_rsp_valid = rsp;
        fif.imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom;
        #1;
        exp_rv = !redir && ((memq.size() + mbuf.size()) < 2);
        check("req_valid", {31'd0, fif.imem_req_valid}, {31'd0, exp_rv});
        check("req_addr", fif.imem_req_addr, exp_req_pc);
        acc      = fif.imem_req_valid && fif.imem_req_ready;
        acc_addr = fif.imem_req_addr;

        @(posedge clk);
        live = 1'b0;
        head.addr = 32'd0;
        head.due  = 0;
        head.ep   = 0;
        if (rsp) begin
            head = memq.pop_front();
            live = (head.ep == epoch) && !redir;
        end
        took = 1'b0;
        if (flush) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            if (mbuf.size() > 0) begin
                m_pc    = mbuf.pop_front();
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
            end else if (live) begin
                m_pc    = head.addr;
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                took    = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (live && !took) mbuf.push_back(head.addr);
        if (acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            nr.addr  = acc_addr;
            nr.due   = due;
            nr.ep    = epoch;
            memq.push_back(nr);
        end
        if (redir) begin
            mbuf.delete();
            epoch++;
            exp_req_pc = {redir_pc[31:2], 2'b00};
        end else if (acc) begin
            exp_req_pc = exp_req_pc + 32'd4;
        end
        cyc++;

        #1;
        check("ifid_valid", {31'd0, fif.if_id_reg.valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("ifid_pc", fif.if_id_reg.pc, m_pc);
            check("ifid_instr", fif.if_id_reg.instr, m_instr);
        end
    endtask

    task automatic rand_inputs();
        redir = ($urandom_range(99, 0) < p_redir);
        flush = redir || ($urandom_range(99, 0) < p_flush);
        stall = ($urandom_range(99, 0) < p_stall);
        fif.imem_req_ready = ($urandom_range(99, 0) < p_ready);
        redir_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                : 32'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, {31'd0, fif.imem_req_valid}, 32'd0);
        check({tag, "_ifid_valid"}, {31'd0, fif.if_id_reg.valid}, 32'd0);
        check({tag, "_ifid_pc"}, fif.if_id_reg.pc, 32'd0);
        check({tag, "_ifid_instr"}, fif.if_id_reg.instr, c_NOP);
    endtask

    initial begin
        logic        found;
        logic [31:0] saved;

        errors = 0;
        checks = 0;
        cyc    = 0;
        epoch  = 0;
        lat_min = 1;
        lat_max = 1;
        p_stall = 0; p_flush = 0; p_redir = 0; p_ready = 100;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'd0;
        fif.imem_req_ready = 1'b1;
        fif.imem_rsp_valid = 1'b0;
        fif.imem_rsp_data  = 32'd0;
        model_reset();

        // Reset values, then streaming at one instruction per cycle.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        tick();
        check("boot_valid", {31'd0, fif.if_id_reg.valid}, 32'd1);
        check("boot_pc0", fif.if_id_reg.pc, 32'h0);
        tick();
        check("boot_pc1", fif.if_id_reg.pc, 32'h4);
        tick();
        check("boot_pc2", fif.if_id_reg.pc, 32'h8);
        repeat (4) tick();

        // Stall back-pressure: buffer fills and requests stop.
        stall = 1'b1;
        repeat (5) tick();
        check("stall_req_valid", {31'd0, fif.imem_req_valid}, 32'd0);
        stall = 1'b0;
        repeat (6) tick();

        // Redirect with two requests in flight at 3-cycle latency.
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (memq.size() == 2);
        end
        check("two_inflight", 32'(memq.size()), 32'd2);
        redir = 1'b1; flush = 1'b1; redir_pc = 32'h0000_0100;
        tick();
        redir = 1'b0; flush = 1'b0;
        check("redir_addr", fif.imem_req_addr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            tick();
            found = fif.if_id_reg.valid;
        end
        check("redir_first_valid", {31'd0, fif.if_id_reg.valid}, 32'd1);
        check("redir_first_pc", fif.if_id_reg.pc, 32'h0000_0100);

        // Flush together with stall: bubble written, buffer retained.
        lat_min = 1;
        lat_max = 1;
        repeat (3) tick();
        stall = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        check("flush_stall_valid", {31'd0, fif.if_id_reg.valid}, 32'd0);
        flush = 1'b0; stall = 1'b0;
        repeat (4) tick();

        // Memory not ready: address held, PC frozen.
        fif.imem_req_ready = 1'b0;
        saved = fif.imem_req_addr;
        repeat (4) tick();
        check("ready_low_addr", fif.imem_req_addr, saved);
        check("ready_low_drain", {31'd0, fif.if_id_reg.valid}, 32'd0);
        fif.imem_req_ready = 1'b1;
        repeat (4) tick();

        // Redirect to a misaligned top-of-memory target and wrap to zero.
        redir = 1'b1; flush = 1'b1; redir_pc = 32'hFFFF_FFFE;
        tick();
        redir = 1'b0; flush = 1'b0;
        check("wrap_addr_top", fif.imem_req_addr, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = (fif.imem_req_addr != 32'hFFFF_FFFC);
        end
        check("wrap_addr_zero", fif.imem_req_addr, 32'h0000_0000);
        repeat (6) tick();

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        p_stall = 20; p_flush = 5; p_redir = 3; p_ready = 70;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        stall = 1'b0; flush = 1'b0; redir = 1'b0;
        fif.imem_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction Fetch (F) stage of the 5-stage RV32IM pipeline and the producer side of the IF/ID interface. Owns the PC and issues word-aligned requests to instruction memory. It tracks up to two in-order outstanding requests and buffers returned instructions in a 2-entry queue. It then drives the registered `if_id_reg_t` (pc, instr, valid) consumed by the decode stage, and honours stall, flush and PC redirect from the hazard and execute logic.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded at reset. Bits [1:0] must be 0.
- `clk_i`  in  1  sole clock, rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `stall_d_i`  in  1  decode stalled: hold IF/ID
- `flush_d_i`  in  1  write a bubble (valid=0) into IF/ID
- `redirect_valid_i`  in  1  control-flow change; load new PC, kill all fetched and in-flight instructions
- `redirect_pc_i`  in  32  redirect target; bits [1:0] ignored (treated as 0)
- `imem_req_valid_o`  out  1  fetch request valid
- `imem_req_addr_o`  out  32  fetch address, always word-aligned
- `imem_req_ready_i`  in  1  memory accepts request (handshake = valid & ready)
- `imem_rsp_valid_i`  in  1  response valid; responses arrive in request order, at least 1 cycle after acceptance, and cannot be back-pressured
- `imem_rsp_data_i`  in  32  instruction word
- `if_id_reg_o`  out  if_id_reg_t  registered IF/ID: pc, instr, valid

## Operation
- **State:**
  - `pc_q`: next fetch address.
  - `out_cnt` (0..2): accepted requests not yet responded.
  - `discard_cnt` (0..2, ≤ out_cnt): outstanding responses to drop.
  - PC-tag FIFO (depth 2): PC of each accepted request.
  - Instruction buffer (depth 2): {pc, instr} pairs.
  - IF/ID register.
- **Request issue:** `imem_req_valid_o` = !redirect_valid_i & (out_cnt + buf_occupancy < 2). `imem_req_addr_o` = pc_q. The memory port permits withdrawing an unaccepted request.
- **On acceptance:**
  - pc_q += 4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
  - Push pc_q into the tag FIFO.
  - out_cnt++.
- **On response:**
  - Pop the tag FIFO; out_cnt--.
  - If discard_cnt > 0: drop the data, discard_cnt--.
  - Otherwise, deliver {tag, data}: bypass into IF/ID if the buffer is empty and IF/ID loads this cycle; else push into the buffer.
  - The credit rule guarantees the buffer never overflows. A push while full is a design error and must be asserted against.
- **IF/ID update priority, highest first:**
  1. flush_d_i → valid=0.
  2. stall_d_i → hold all fields.
  3. Buffer non-empty → load head, pop.
  4. Bypassed response → load it.
  5. Otherwise → valid=0.
  - flush_d_i overrides stall_d_i.
  - redirect_valid_i alone does not alter IF/ID. The hazard unit asserts flush_d_i in the same cycle.
- **Redirect (cycle R):**
  - pc_q ← {redirect_pc_i[31:2], 2'b00}.
  - Buffer cleared; any response arriving in R is dropped.
  - discard_cnt ← out_cnt after R's response is accounted for.
  - No request issues in R; the first request to the target issues in R+1.
  - A redirect in consecutive cycles: the last one wins; discard_cnt accumulates correctly.
- **Simultaneous events in one cycle:** accept, response and pop update the counters net. out_cnt, discard_cnt and occupancy never go negative or exceed 2.

## Timing
- **Reset values (rst_ni low, asynchronous):**
  - pc_q=RESET_VECTOR; out_cnt=discard_cnt=0; buffer and tag FIFO empty.
  - if_id_reg_o: valid=0, pc=0, instr=32'h0000_0013 (NOP).
  - imem_req_valid_o=0 while in reset. The first request to RESET_VECTOR is presented in the first cycle after deassertion.
- **Latency:** a request accepted at cycle N with its response at N+k (empty buffer, no stall) gives if_id_reg_o.valid=1 at N+k+1.
- **Throughput:** one instruction per cycle with 1-cycle memory latency and no stall.
- **Reset mid-operation:** all state clears. Responses to pre-reset requests must not arrive after reset (memory is reset together with the core).

## Test plan
- **Reset:** release reset, imem ready=1, 1-cycle rsp → requests 0x0, 0x4, 0x8 on consecutive cycles; IF/ID pc 0x0, 0x4, 0x8 valid from cycle 2; one instruction per cycle.
- **Stall backpressure:** assert stall_d_i for 5 cycles mid-stream → IF/ID held; buffer fills to 2; imem_req_valid_o drops to 0; release → pc sequence continues with no gap, duplicate or loss.
- **Redirect with 2 in flight:** 3-cycle memory latency, two requests outstanding, redirect_valid_i+flush_d_i to 0x100 → both old responses dropped; first request 0x100 in R+1; next valid IF/ID pc=0x100.
- **Flush vs stall:** stall_d_i=1 and flush_d_i=1 together → IF/ID valid=0 next cycle; buffer contents retained.
- **Ready low:** imem_req_ready_i=0 for 4 cycles → addr stable at the current pc_q; pc_q does not advance; no spurious IF/ID valid.
- **Edge cases:** redirect to 0xFFFF_FFFE → fetch 0xFFFF_FFFC then 0x0000_0000; async reset asserted mid-stream → all outputs at reset values immediately.
